// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate walks the taps, one tap
// per clock, over a circular sample history and a software-loadable coefficient bank.
module fir_mac_sequencer #(
  parameter int TAPS   = 4,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  localparam int IDX_W = $clog2(TAPS),
  localparam int OUT_W = DATA_W + COEF_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              coef_we,
  input  logic [IDX_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(TAPS - 1);

  typedef enum logic {IDLE, MAC} state_t;
  state_t state, state_nx;

  logic [TAPS-1:0][DATA_W-1:0] hist;
  logic [TAPS-1:0][COEF_W-1:0] coef;
  logic [IDX_W-1:0]            wptr, wnext, k, tap_idx;
  logic [PROD_W-1:0]           prod;
  logic [OUT_W-1:0]            acc, acc_nx;

  // Tap k reads k samples back from the newest one; index wraps modulo TAPS.
  assign tap_idx = wptr - k;
  assign wnext   = wptr + IDX_W'(1);
  assign prod    = {{COEF_W{1'b0}}, hist[tap_idx]} * {{DATA_W{1'b0}}, coef[k]};
  assign acc_nx  = acc + {{IDX_W{1'b0}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    x_ready  = 1'b0;
    case (state)
      IDLE: begin
        x_ready = 1'b1;
        if (x_valid) state_nx = MAC;
      end
      MAC: if (k == K_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = ~x_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= '0;
      coef    <= '0;
      coef[0] <= COEF_W'(1);
      wptr    <= '0;
      k       <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Coefficient lands on this edge, so a same-edge sample already sees it.
          if (coef_we) coef[coef_addr] <= coef_data;
          if (x_valid) begin
            hist[wnext] <= x;
            wptr        <= wnext;
            acc         <= '0;
            k           <= '0;
          end
        end
        MAC: begin
          if (k == K_LAST) begin
            y       <= acc_nx;
            y_valid <= 1'b1;
            k       <= '0;
          end else begin
            acc <= acc_nx;
            k   <= k + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: a sample-level convolution model is
// compared against the DUT every cycle, plus literal output sequences per scenario.
module tb_fir_mac_sequencer;
  localparam int TAPS = 4, DATA_W = 8, COEF_W = 8, IDX_W = 2, OUT_W = 18;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] x = '0;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic              coef_we = 1'b0;
  logic [IDX_W-1:0]  coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic [OUT_W-1:0]  y;
  logic              y_valid;
  logic              busy;

  int checks = 0, failures = 0;
  int got[$];
  int exp_q[$];

  fir_mac_sequencer #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y(y), .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  // Model: newest-first sample list, coefficient array, and a countdown of
  // cycles left in the current MAC sequence.
  int m_samp[TAPS];
  int m_coef[TAPS];
  int m_busy = 0;
  int m_y = 0;
  bit m_yv = 1'b0;
  int m_pend = 0;
  bit started = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        m_samp[i] = 0;
        m_coef[i] = (i == 0) ? 1 : 0;
      end
      m_busy = 0; m_y = 0; m_yv = 1'b0;
    end else begin
      m_yv = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_yv = 1'b1;
          m_y  = m_pend;
        end
      end else begin
        if (coef_we) m_coef[coef_addr] = int'(coef_data);
        if (x_valid) begin
          for (int i = TAPS - 1; i > 0; i--) m_samp[i] = m_samp[i-1];
          m_samp[0] = int'(x);
          m_pend = 0;
          for (int i = 0; i < TAPS; i++) m_pend += m_coef[i] * m_samp[i];
          m_busy = TAPS;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("y_valid", y_valid, m_yv);
      chk("x_ready", x_ready, (m_busy == 0));
      chk("busy", busy, (m_busy != 0));
      chk("y", y, m_y);
      if (y_valid && !rst) got.push_back(int'(y));
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !x_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!x_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input int v);
    wait_ready();
    x = DATA_W'(v); x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    wait_ready();
    coef_addr = IDX_W'(a); coef_data = COEF_W'(d); coef_we = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic expect_got(input string nm);
    for (int i = 0; i < 200 && got.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, got[i], exp_q[i]);
    got.delete();
  endtask

  initial begin
    int acc_cnt;
    #1 rst = 1'b1;
    started = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_x_ready", x_ready, 1);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);

    // 1: defaults pass samples straight through
    foreach (exp_q[i]) ;
    exp_q = '{5, 10, 12, 15, 16};
    foreach (exp_q[i]) send(exp_q[i]);
    expect_got("t1_passthru");

    // 2: loaded taps, fifth output wraps the pointer
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    send(5); send(10); send(12); send(15); send(16);
    exp_q = '{5, 20, 47, 89, 122};
    expect_got("t2_taps");

    // 3: x_valid held high; offered-while-busy samples must not enter history
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    acc_cnt = 0;
    x = 8'd7; x_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (x_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    chk("t3_accepts", acc_cnt, 4);
    exp_q = '{7, 21, 42, 70};
    expect_got("t3_hold");

    // 4: coefficient write during MAC is dropped; in IDLE with a sample it applies
    do_reset();
    send(5);
    coef_addr = '0; coef_data = 8'd9; coef_we = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0;
    send(3);
    wait_ready();
    coef_addr = '0; coef_data = 8'd9; coef_we = 1'b1;
    x = 8'd2; x_valid = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0; x_valid = 1'b0;
    exp_q = '{5, 3, 18};
    expect_got("t4_coefwr");

    // 5: full-scale operands
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, 255);
    repeat (4) send(255);
    exp_q = '{65025, 130050, 195075, 260100};
    expect_got("t5_max");

    // 6: async reset two cycles into MAC
    do_reset();
    wcoef(1, 3);
    send(4);
    exp_q = '{4};
    expect_got("t6_pre");
    send(9);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_y", y, 0);
    chk("t6_y_valid", y_valid, 0);
    chk("t6_x_ready", x_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
    send(5);
    exp_q = '{5};
    expect_got("t6_post");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
